ahb_protocol_checker: RTL and testbench
=======================================

// Module: ahb_protocol_checker
// PURPOSE
//  Passive, synthesisable AHB protocol checker that observes one master/slave link, replacing fixed-config assertions.
//  Parametrised in address and data width and in wait-state limit. Wait states, bursts and ERROR responses are all legal input.
//  Tracks burst progress, wait states and responses, and reports violations as sticky error bits, a saturating count and an IRQ.
//  Sits beside the bus in testbench or silicon debug; it never drives any AHB signal.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width: 32, 64 or 128
//  MAX_WAIT  16  maximum consecutive HREADY=0 cycles allowed during a valid transfer
//  CNT_W     8   width of err_cnt
// PORTS
//  HCLK     in   1       bus clock; all logic on posedge
//  HRESET   in   1       asynchronous, active-high reset
//  HADDR    in   ADDR_W  address
//  HTRANS   in   2       IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//  HWRITE   in   1       direction
//  HSIZE    in   3       transfer size, log2 of bytes
//  HBURST   in   3       SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16
//  HREADY   in   1       transfer done / address-phase accept
//  HRESP    in   1       0=OKAY, 1=ERROR
//  err_clr  in   1       1-cycle pulse; clears err_vec and err_cnt
//  err_mask in   8       per-bit IRQ enable
//  err_vec  out  8       sticky violation flags
//  err_cnt  out  CNT_W   total violation events, saturating
//  irq      out  1       registered |(err_vec & err_mask)
//  in_burst out  1       a burst is in progress
// BEHAVIOUR
//  Reset: all outputs 0, FSMs to IDLE/OKAY, all counters 0. HRESET asserted mid-burst abandons all tracking.
//  Accept: an address phase is accepted on the edge where HTRANS is NONSEQ or SEQ and HREADY=1.
//    The accepted address, size, burst and beat number are registered.
//  Burst FSM, IDLE -> BURST:
//    Taken on an accepted NONSEQ with HBURST != SINGLE. Beat counter set to 1; in_burst=1.
//  Burst FSM, in BURST:
//    An accepted SEQ increments the beat counter.
//    Returns to IDLE when the beat count reaches the burst length (4/8/16), or on NONSEQ or IDLE.
//    For INCR bursts, it returns to IDLE only on NONSEQ or IDLE.
//  Response FSM: OKAY -> ERR1 on HRESP=1 with HREADY=0. In ERR1, the next cycle must show HRESP=1, HREADY=1.
//  Error bits (a violation sampled at edge N sets its bit at edge N, visible in the following cycle):
//   [0] SEQ or BUSY while the burst FSM is IDLE
//   [1] SEQ address != expected address
//       INCR: previous address + 2^HSIZE
//       WRAP: wrap inside a (beats * 2^HSIZE)-aligned window
//   [2] HSIZE > log2(DATA_W/8)
//   [3] HADDR not aligned to 2^HSIZE on NONSEQ/SEQ
//   [4] HADDR/HTRANS/HWRITE/HSIZE/HBURST changed while HREADY=0 with HTRANS NONSEQ/SEQ
//       Exception: an ERROR response is in progress.
//   [5] wait counter > MAX_WAIT
//       Counts consecutive HREADY=0 cycles with a pending data phase; cleared when HREADY=1.
//       Saturates at MAX_WAIT+1; flags once per stall.
//   [6] ERROR response malformed: HRESP=1 with HREADY=1 not preceded by ERR1, or ERR1 not followed by HRESP=1.
//   [7] fixed-length burst terminated early by NONSEQ/IDLE
//       Exception: an ERROR response occurred in that burst.
//  err_cnt adds the number of bits firing that edge, saturating at 2^CNT_W-1. Several bits may fire on one edge.
//  err_clr and a new violation on the same edge: the clear applies first, then the new bits set (new event wins).
//  irq follows err_vec one cycle later.
//  BUSY inside a burst: no beat increment and no address check; the wait counter is unaffected.
// CONFIGURATION
//  AHB_CHK_ASSERT_EN
//   Defined: each violation also issues a $error with bit index, HADDR and $time (simulation only).
//   Undefined: no messages; flags, count and IRQ only. Hardware behaviour is identical either way.
// TESTING
//  1. INCR4 words at 0x100: NONSEQ, then SEQ 0x104/0x108/0x10C, HREADY=1
//     -> err_vec=0; in_burst high 4 cycles.
//  2. WRAP4 words at 0x38: expect 0x3C, 0x30, 0x34. Drive 0x40 as beat 2
//     -> err_vec[1]=1, err_cnt=1.
//  3. MAX_WAIT=16, HREADY=0 for 17 cycles during NONSEQ
//     -> err_vec[5] set at the 17th edge, err_cnt=1; irq next cycle if mask[5]=1.
//  4. HRESP=1 and HREADY=1 in a single cycle with no prior ERR1
//     -> err_vec[6]=1. Proper 2-cycle ERROR -> no flag.
//  5. INCR8 terminated by IDLE after 3 beats -> err_vec[7]=1.
//     The same with an ERROR response on beat 3 -> no flag.
//  6. DATA_W=32, HSIZE=3'b011 at HADDR=0x2
//     -> err_vec[2] and err_vec[3] set on the same edge, err_cnt=2.
//     Pulse err_clr with a concurrent SEQ-from-IDLE -> err_vec=0x01, err_cnt=1.

Source files
------------

// File: rtl/ahb_protocol_checker.sv
// Passive AHB link checker: sticky violation flags, saturating event count and masked IRQ.
// Define AHB_CHK_ASSERT_EN to also get a simulation $error for each violation.
module ahb_protocol_checker #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic              HREADY,
   input  logic              HRESP,
   input  logic              err_clr,
   input  logic [7:0]        err_mask,
   output logic [7:0]        err_vec,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              irq,
   output logic              in_burst
);

   localparam logic [2:0] MaxSize = 3'($clog2(DATA_W / 8));
   localparam int unsigned WaitW = $clog2(MAX_WAIT + 2);
   localparam logic [WaitW-1:0] WaitLim = WaitW'(MAX_WAIT);

   typedef enum logic {BurstIdle, BurstRun} burst_state_e;
   typedef enum logic {RespOkay, RespErr1} resp_state_e;

   function automatic logic [4:0] burst_len(input logic [2:0] b);
      case (b[2:1])
         2'b01:   return 5'd4;
         2'b10:   return 5'd8;
         2'b11:   return 5'd16;
         default: return 5'd0;
      endcase
   endfunction

   // Wrapping bursts stay inside a (beats << size)-aligned window.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] s,
                                                   input logic [2:0] b);
      logic [ADDR_W-1:0] inc;
      logic [ADDR_W-1:0] win;
      inc = a + (ADDR_W'(1) << s);
      win = (ADDR_W'(burst_len(b)) << s) - ADDR_W'(1);
      if (b[2:1] != 2'b00 && !b[0]) return (a & ~win) | (inc & win);
      return inc;
   endfunction

   burst_state_e      burst_st_q, burst_st_d;
   resp_state_e       resp_st_q, resp_st_d;
   logic [2:0]        burst_q, burst_d;
   logic [2:0]        size_q, size_d;
   logic [4:0]        beat_q, beat_d;
   logic [ADDR_W-1:0] exp_q, exp_d;
   logic              berr_q, berr_d;
   logic              pend_q, pend_d;
   logic [WaitW-1:0]  wait_q, wait_d;
   logic              hold_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [1:0]        ptrans_q;
   logic              pwrite_q;
   logic [2:0]        psize_q;
   logic [2:0]        pburst_q;
   logic [7:0]        vec_q, vec_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              irq_q;
   logic [7:0]        fire;

   logic is_idle, is_busy, is_nonseq, is_seq, accept, fixed, burst_done, eff_idle;
   logic [CNT_W-1:0] base;
   logic [CNT_W+3:0] sum;
   logic [3:0]       n_fire;

   always_comb begin
      is_idle    = HTRANS == 2'b00;
      is_busy    = HTRANS == 2'b01;
      is_nonseq  = HTRANS == 2'b10;
      is_seq     = HTRANS == 2'b11;
      accept     = HTRANS[1] & HREADY;
      fixed      = burst_q[2:1] != 2'b00;
      // A full fixed burst lingers in BurstRun until its last data phase completes.
      burst_done = burst_st_q == BurstRun && fixed && beat_q == burst_len(burst_q);
      eff_idle   = burst_st_q == BurstIdle || burst_done;
   end

   // Burst tracking
   always_comb begin
      burst_st_d = burst_st_q;
      burst_d    = burst_q;
      size_d     = size_q;
      beat_d     = beat_q;
      exp_d      = exp_q;
      berr_d     = berr_q | (burst_st_q == BurstRun && HRESP);
      if (HREADY) begin
         if (is_nonseq) begin
            burst_d    = HBURST;
            size_d     = HSIZE;
            beat_d     = 5'd1;
            exp_d      = next_addr(HADDR, HSIZE, HBURST);
            berr_d     = 1'b0;
            burst_st_d = (HBURST != 3'b000) ? BurstRun : BurstIdle;
         end else if (is_seq && burst_st_q == BurstRun && !burst_done) begin
            beat_d = beat_q + {4'd0, beat_q != 5'd31};
            exp_d  = next_addr(HADDR, size_q, burst_q);
         end else if (is_idle || burst_done) begin
            burst_st_d = BurstIdle;
         end
      end
   end

   // Response, wait-state and flag logic
   always_comb begin
      resp_st_d = resp_st_q;
      wait_d    = wait_q;
      pend_d    = HREADY ? accept : pend_q;
      fire      = 8'h00;

      fire[0] = HREADY && (is_seq || is_busy) && eff_idle;
      fire[1] = accept && is_seq && burst_st_q == BurstRun && !burst_done && HADDR != exp_q;
      fire[2] = accept && HSIZE > MaxSize;
      fire[3] = accept && (HADDR & ((ADDR_W'(1) << HSIZE) - ADDR_W'(1))) != '0;
      fire[4] = hold_q && !(resp_st_q == RespErr1 || HRESP) &&
                (HADDR != paddr_q || HTRANS != ptrans_q || HWRITE != pwrite_q ||
                 HSIZE != psize_q || HBURST != pburst_q);

      if (!(!HREADY && (pend_q || HTRANS[1]))) begin
         wait_d = '0;
      end else if (wait_q <= WaitLim) begin
         wait_d  = wait_q + WaitW'(1);
         fire[5] = wait_q == WaitLim;
      end

      unique case (resp_st_q)
         RespOkay: begin
            if (HRESP && !HREADY) resp_st_d = RespErr1;
            else if (HRESP)       fire[6]   = 1'b1;
         end
         RespErr1: begin
            resp_st_d = RespOkay;
            fire[6]   = !(HRESP && HREADY);
         end
         default: resp_st_d = RespOkay;
      endcase

      fire[7] = HREADY && burst_st_q == BurstRun && fixed && !burst_done &&
                (is_nonseq || is_idle) && !(berr_q || HRESP);

      n_fire = 4'd0;
      for (int i = 0; i < 8; i++) n_fire = n_fire + {3'd0, fire[i]};

      // Clear first, then this edge's events land on top.
      base  = err_clr ? '0 : cnt_q;
      vec_d = (err_clr ? 8'h00 : vec_q) | fire;
      sum   = {4'd0, base} + {{CNT_W{1'b0}}, n_fire};
      cnt_d = (sum > {4'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         burst_st_q <= BurstIdle;
         resp_st_q  <= RespOkay;
         burst_q    <= 3'b000;
         size_q     <= 3'b000;
         beat_q     <= 5'd0;
         exp_q      <= '0;
         berr_q     <= 1'b0;
         pend_q     <= 1'b0;
         wait_q     <= '0;
         hold_q     <= 1'b0;
         paddr_q    <= '0;
         ptrans_q   <= 2'b00;
         pwrite_q   <= 1'b0;
         psize_q    <= 3'b000;
         pburst_q   <= 3'b000;
         vec_q      <= 8'h00;
         cnt_q      <= '0;
         irq_q      <= 1'b0;
      end else begin
         burst_st_q <= burst_st_d;
         resp_st_q  <= resp_st_d;
         burst_q    <= burst_d;
         size_q     <= size_d;
         beat_q     <= beat_d;
         exp_q      <= exp_d;
         berr_q     <= berr_d;
         pend_q     <= pend_d;
         wait_q     <= wait_d;
         hold_q     <= HTRANS[1] & ~HREADY;
         paddr_q    <= HADDR;
         ptrans_q   <= HTRANS;
         pwrite_q   <= HWRITE;
         psize_q    <= HSIZE;
         pburst_q   <= HBURST;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         irq_q      <= |(vec_q & err_mask);
      end
   end

`ifdef AHB_CHK_ASSERT_EN
   always_ff @(posedge HCLK) begin
      for (int i = 0; i < 8; i++) begin
         if (!HRESET && fire[i])
            $error("ahb_protocol_checker: violation bit %0d HADDR=%0h at %0t", i, HADDR, $time);
      end
   end
`else
   // Silent build: violations surface only through err_vec, err_cnt and irq.
`endif

   assign err_vec  = vec_q;
   assign err_cnt  = cnt_q;
   assign irq      = irq_q;
   assign in_burst = burst_st_q == BurstRun;

endmodule

// File: tb/tb_ahb_protocol_checker.sv
// Directed bench for ahb_protocol_checker: bursts, waits, error responses, flag clearing.
module tb_ahb_protocol_checker;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic        HREADY;
   logic        HRESP;
   logic        err_clr;
   logic [7:0]  err_mask;
   logic [7:0]  err_vec;
   logic [7:0]  err_cnt;
   logic        irq;
   logic        in_burst;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] TIdle = 2'b00, TNonseq = 2'b10, TSeq = 2'b11;
   localparam logic [2:0] BSingle = 3'b000, BWrap4 = 3'b010, BIncr4 = 3'b011, BIncr8 = 3'b101;

   ahb_protocol_checker #(
      .ADDR_W(32), .DATA_W(32), .MAX_WAIT(16), .CNT_W(8)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .err_clr(err_clr),
      .err_mask(err_mask), .err_vec(err_vec), .err_cnt(err_cnt), .irq(irq),
      .in_burst(in_burst)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic [1:0] t, input logic [31:0] a, input logic [2:0] s,
                      input logic [2:0] b, input logic r, input logic rs);
      HTRANS = t; HADDR = a; HSIZE = s; HBURST = b; HREADY = r; HRESP = rs; HWRITE = 1'b0;
   endtask

   task automatic idle_clr();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   initial begin
      HRESET = 1'b1; err_clr = 1'b0; err_mask = 8'h00;
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b0);
      tick(); tick();
      chk("rst_vec", err_vec, 8'h00);
      chk("rst_cnt", err_cnt, 8'd0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_burst", in_burst, 1'b0);
      HRESET = 1'b0;
      tick();

      // INCR4 of words, clean
      drv(TNonseq, 32'h100, 3'd2, BIncr4, 1'b1, 1'b0); tick();
      chk("incr4_b1", in_burst, 1'b1);
      drv(TSeq, 32'h104, 3'd2, BIncr4, 1'b1, 1'b0); tick();
      chk("incr4_b2", in_burst, 1'b1);
      drv(TSeq, 32'h108, 3'd2, BIncr4, 1'b1, 1'b0); tick();
      chk("incr4_b3", in_burst, 1'b1);
      drv(TSeq, 32'h10C, 3'd2, BIncr4, 1'b1, 1'b0); tick();
      chk("incr4_b4", in_burst, 1'b1);
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b0); tick();
      chk("incr4_end", in_burst, 1'b0);
      chk("incr4_vec", err_vec, 8'h00);
      chk("incr4_cnt", err_cnt, 8'd0);

      // WRAP4 at 0x38 expects 0x3C next; 0x40 is a bad address
      idle_clr();
      drv(TNonseq, 32'h38, 3'd2, BWrap4, 1'b1, 1'b0); tick();
      drv(TSeq, 32'h40, 3'd2, BWrap4, 1'b1, 1'b0); tick();
      chk("wrap_vec", err_vec, 8'h02);
      chk("wrap_cnt", err_cnt, 8'd1);
      chk("wrap_inb", in_burst, 1'b1);
      // Reset mid-burst drops all tracking
      HRESET = 1'b1; #2;
      chk("mid_rst_inb", in_burst, 1'b0);
      chk("mid_rst_vec", err_vec, 8'h00);
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b0); tick();
      HRESET = 1'b0;

      // 17 wait states on a NONSEQ
      idle_clr();
      err_mask = 8'h20;
      drv(TNonseq, 32'h200, 3'd2, BSingle, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) tick();
      chk("wait16_vec", err_vec, 8'h00);
      tick();
      chk("wait17_vec", err_vec, 8'h20);
      chk("wait17_cnt", err_cnt, 8'd1);
      chk("wait17_irq", irq, 1'b0);
      tick();
      chk("wait18_irq", irq, 1'b1);
      chk("wait18_cnt", err_cnt, 8'd1);
      HREADY = 1'b1; tick();
      chk("wait_acc_cnt", err_cnt, 8'd1);

      // One-cycle ERROR, then proper two-cycle ERROR, then ERR1 without follow-up
      idle_clr();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b1); tick();
      chk("err1cyc_vec", err_vec, 8'h40);
      chk("err1cyc_cnt", err_cnt, 8'd1);
      idle_clr();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b0, 1'b1); tick();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b1); tick();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b0); tick();
      chk("err2cyc_vec", err_vec, 8'h00);
      chk("err2cyc_cnt", err_cnt, 8'd0);
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b0, 1'b1); tick();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b0); tick();
      chk("errbad_vec", err_vec, 8'h40);

      // Address changed during a stall
      idle_clr();
      drv(TNonseq, 32'h300, 3'd2, BSingle, 1'b0, 1'b0); tick();
      drv(TNonseq, 32'h304, 3'd2, BSingle, 1'b0, 1'b0); tick();
      chk("hold_vec", err_vec, 8'h10);
      chk("hold_cnt", err_cnt, 8'd1);
      HREADY = 1'b1; tick();
      chk("hold_acc_cnt", err_cnt, 8'd1);

      // INCR8 cut short after 3 beats
      idle_clr();
      drv(TNonseq, 32'h400, 3'd2, BIncr8, 1'b1, 1'b0); tick();
      drv(TSeq, 32'h404, 3'd2, BIncr8, 1'b1, 1'b0); tick();
      drv(TSeq, 32'h408, 3'd2, BIncr8, 1'b1, 1'b0); tick();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b0); tick();
      chk("early_vec", err_vec, 8'h80);
      chk("early_cnt", err_cnt, 8'd1);
      chk("early_inb", in_burst, 1'b0);
      // Same, but beat 3 takes an ERROR response
      idle_clr();
      drv(TNonseq, 32'h400, 3'd2, BIncr8, 1'b1, 1'b0); tick();
      drv(TSeq, 32'h404, 3'd2, BIncr8, 1'b1, 1'b0); tick();
      drv(TSeq, 32'h408, 3'd2, BIncr8, 1'b1, 1'b0); tick();
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b0, 1'b1); tick();
      chk("errbst_inb", in_burst, 1'b1);
      drv(TIdle, 32'h0, 3'd2, BSingle, 1'b1, 1'b1); tick();
      chk("errbst_vec", err_vec, 8'h00);
      chk("errbst_cnt", err_cnt, 8'd0);
      chk("errbst_end", in_burst, 1'b0);

      // Oversize and misaligned on one edge; clear racing a new SEQ-from-IDLE
      idle_clr();
      drv(TNonseq, 32'h2, 3'd3, BSingle, 1'b1, 1'b0); tick();
      chk("size_vec", err_vec, 8'h0C);
      chk("size_cnt", err_cnt, 8'd2);
      drv(TSeq, 32'h10, 3'd2, BSingle, 1'b1, 1'b0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("clr_vec", err_vec, 8'h01);
      chk("clr_cnt", err_cnt, 8'd1);
      chk("clr_irq_masked", irq, 1'b0);

      // Three events per edge for 90 edges saturates the count
      idle_clr();
      drv(TSeq, 32'h2, 3'd3, BSingle, 1'b1, 1'b0);
      for (int i = 0; i < 90; i++) tick();
      chk("sat_cnt", err_cnt, 8'd255);
      chk("sat_vec", err_vec, 8'h0D);
      idle_clr();
      chk("sat_clr", err_cnt, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
